// File: rtl/axi_reg_arb_pkg.sv
// Shared types and constants for the two-requester
// AXI4-Lite master arbiter.
package axi_reg_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int C_ADDR_LSB = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant,
// registered memory of the last accepted winner.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie, favour the requester that did not win last.
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_grant_q);
    grant[1] = req[1] & (~req[0] | ~last_grant_q);
  end

  // Remember the winner only when the grant is taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant[1];
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/axi_reg_list_master_arb.sv
// Shares one AXI4-Lite master between two requesters,
// one transaction in flight at a time.
module axi_reg_list_master_arb
  import axi_reg_arb_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REQ          = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_NUM_REQ-1:0]            req_valid,
  output logic [C_NUM_REQ-1:0]            req_ready,
  input  logic [C_NUM_REQ-1:0]            req_write,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [C_NUM_REQ-1:0]            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            owner_q, owner_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;

  logic [1:0]      gnt;
  logic            accept;
  logic            sel;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            aw_hs;
  logic            w_hs;

  rr_arbiter_2 u_arb (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .req    (req_valid),
    .accept (accept),
    .grant  (gnt)
  );

  assign sel       = gnt[1];
  assign sel_addr  = sel ? req_addr[AW +: AW]
                         : req_addr[0 +: AW];
  assign sel_wdata = sel ? req_wdata[DW +: DW]
                         : req_wdata[0 +: DW];
  assign aw_hs     = awvalid_q & M_AXI_AWREADY;
  assign w_hs      = wvalid_q & M_AXI_WREADY;

  // Grant pulse is only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (ARESETN && state_q == IDLE) req_ready = gnt;
  end

  assign accept = |req_ready;

  // Next-state and next-output computation for the FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = sel;
          addr_d  = sel_addr;
          addr_d[C_ADDR_LSB-1:0] = '0;
          wdata_d = sel_wdata;
          if (req_write[sel]) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready_q && M_AXI_BVALID) begin
          state_d     = DONE;
          bready_d    = 1'b0;
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      RD_REQ: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (rready_q && M_AXI_RVALID) begin
          state_d     = DONE;
          rready_d    = 1'b0;
          resp_d      = M_AXI_RRESP;
          rdata_d     = M_AXI_RDATA;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi_reg_list_master_arb.sv
// Directed bench for the two-requester AXI4-Lite
// master arbiter, with a small register-list slave.
module tb_axi_reg_list_master_arb;
  import axi_reg_arb_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid, rsp_resp;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWADDR, ARADDR, WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RVALID, RREADY;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_reg_list_master_arb dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
    .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA),
    .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  // Slave model: 4 registers, ready signals set by the bench,
  // responses one cycle after the address/data handshakes.
  logic [31:0] mem [4];
  logic        aw_got, w_got, ag, wg;
  logic [3:0]  aw_a, na, last_awaddr;
  logic [31:0] w_d, nd;
  logic [1:0]  bresp_val, rresp_val;

  assign BRESP = bresp_val;
  assign RRESP = rresp_val;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      BVALID <= 1'b0;
      RVALID <= 1'b0;
    end else begin
      ag = aw_got | (AWVALID & AWREADY);
      wg = w_got | (WVALID & WREADY);
      na = (AWVALID & AWREADY) ? AWADDR : aw_a;
      nd = (WVALID & WREADY) ? WDATA : w_d;
      if (AWVALID && AWREADY) last_awaddr <= AWADDR;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ag && wg) begin
        mem[na[3:2]] <= nd;
        BVALID <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= ag;
        w_got  <= wg;
        aw_a   <= na;
        w_d    <= nd;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RDATA  <= mem[ARADDR[3:2]];
        RVALID <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic grant_wait(input logic [1:0] m,
                            input string tag);
    int n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge ACLK); #1;
      n++;
    end
    chk(tag, {30'd0, req_ready}, {30'd0, m});
  endtask

  // Drops the granted request, then waits for completion.
  task automatic rsp_wait(input logic [1:0] m,
                          input logic [31:0] er,
                          input logic [1:0] es,
                          input string tag);
    int n = 1;
    @(negedge ACLK); #1;
    req_valid = req_valid & ~m;
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge ACLK); #1;
      n++;
    end
    chk({tag, "_who"}, {30'd0, rsp_valid}, {30'd0, m});
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_rdata"}, rsp_rdata, er);
    chk({tag, "_resp"}, {30'd0, rsp_resp}, {30'd0, es});
  endtask

  task automatic txn(input int r, input logic wr,
                     input logic [3:0] a,
                     input logic [31:0] d,
                     input logic [31:0] er,
                     input logic [1:0] es,
                     input string tag);
    logic [1:0] m;
    m = (r == 1) ? 2'b10 : 2'b01;
    @(negedge ACLK);
    req_write[r] = wr;
    req_addr[r*4 +: 4] = a;
    req_wdata[r*32 +: 32] = d;
    req_valid[r] = 1'b1;
    #1;
    grant_wait(m, {tag, "_g"});
    rsp_wait(m, er, es, tag);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  logic [3:0] t3e [7];

  initial begin
    t3e = '{4'b1100, 4'b1000, 4'b1000, 4'b1000,
            4'b0010, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) mem[i] = '0;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    AWREADY = 1'b1;
    WREADY  = 1'b1;
    ARREADY = 1'b1;
    bresp_val = RESP_OKAY;
    rresp_val = RESP_OKAY;
    last_awaddr = '0;

    // Reset: everything quiet even with requests pending.
    repeat (2) @(negedge ACLK);
    #1;
    chk("rst_ready", {30'd0, req_ready}, 0);
    chk("rst_axi", {27'd0, AWVALID, WVALID, BREADY,
                    ARVALID, RREADY}, 0);
    chk("rst_rsp", {28'd0, rsp_valid, rsp_resp}, 0);
    req_valid = 2'b00;
    @(negedge ACLK);
    ARESETN = 1'b1;

    // 1: single write with cycle-by-cycle check, then read back.
    @(negedge ACLK);
    req_write = 2'b01;
    req_addr  = {4'h0, 4'h4};
    req_wdata = {32'h0, 32'hA5A50001};
    req_valid = 2'b01;
    #1;
    chk("t1_grant", {30'd0, req_ready}, 2'b01);
    @(negedge ACLK); #1;
    req_valid = 2'b00;
    chk("t1_awv", {30'd0, AWVALID, WVALID}, 2'b11);
    chk("t1_awaddr", {28'd0, AWADDR}, 4'h4);
    chk("t1_wdata", WDATA, 32'hA5A50001);
    chk("t1_strb", {25'd0, WSTRB, AWPROT}, 7'h78);
    @(negedge ACLK); #1;
    chk("t1_b", {30'd0, BVALID, BREADY}, 2'b11);
    @(negedge ACLK); #1;
    chk("t1_rsp", {28'd0, rsp_valid, rsp_resp}, 4'b0100);
    chk("t1_wr_rdata", rsp_rdata, 0);
    @(negedge ACLK); #1;
    chk("t1_pulse", {30'd0, rsp_valid}, 0);
    txn(0, 1'b0, 4'h4, 0, 32'hA5A50001, 2'b00, "t1_rd");
    chk("t1_arprot", {29'd0, ARPROT}, 0);

    // 2: simultaneous requests after reset alternate.
    do_reset();
    @(negedge ACLK);
    req_write = 2'b11;
    req_addr  = {4'h8, 4'h0};
    req_wdata = {32'd3, 32'd1};
    req_valid = 2'b11;
    #1;
    grant_wait(2'b01, "t2_g0");
    rsp_wait(2'b01, 0, 2'b00, "t2_r0");
    grant_wait(2'b10, "t2_g1");
    rsp_wait(2'b10, 0, 2'b00, "t2_r1");
    @(negedge ACLK);
    req_addr  = {4'hC, 4'h4};
    req_wdata = {32'h22, 32'h11};
    req_valid = 2'b11;
    #1;
    grant_wait(2'b01, "t2_g2");
    rsp_wait(2'b01, 0, 2'b00, "t2_r2");
    grant_wait(2'b10, "t2_g3");
    rsp_wait(2'b10, 0, 2'b00, "t2_r3");

    // 3: AWREADY held off three cycles, WREADY immediate.
    @(negedge ACLK);
    AWREADY   = 1'b0;
    req_write = 2'b01;
    req_addr  = {4'h0, 4'hC};
    req_wdata = {32'h0, 32'h33};
    req_valid = 2'b01;
    #1;
    grant_wait(2'b01, "t3_g");
    for (int i = 0; i < 7; i++) begin
      @(negedge ACLK);
      if (i == 0) req_valid = 2'b00;
      if (i == 3) AWREADY = 1'b1;
      #1;
      chk($sformatf("t3_c%0d", i),
          {28'd0, AWVALID, WVALID, BREADY, rsp_valid[0]},
          {28'd0, t3e[i]});
    end

    // 4: fill all four registers, then read them back.
    for (int i = 0; i < 4; i++)
      txn(i % 2, 1'b1, 4'(i * 4), 32'(i + 1), 0, 2'b00,
          $sformatf("t4_w%0d", i));
    for (int i = 0; i < 4; i++)
      txn((i + 1) % 2, 1'b0, 4'(i * 4), 0, 32'(i + 1),
          2'b00, $sformatf("t4_r%0d", i));

    // 5: reset in WR_RESP, then tie goes to requester 0.
    @(negedge ACLK);
    req_write = 2'b01;
    req_addr  = {4'h0, 4'h8};
    req_wdata = {32'h0, 32'h55};
    req_valid = 2'b01;
    #1;
    grant_wait(2'b01, "t5_g");
    @(negedge ACLK); #1;
    req_valid = 2'b00;
    @(negedge ACLK); #1;
    chk("t5_in_bresp", {31'd0, BREADY}, 1);
    ARESETN = 1'b0;
    @(negedge ACLK); #1;
    chk("t5_rst_axi", {27'd0, AWVALID, WVALID, BREADY,
                       ARVALID, RREADY}, 0);
    chk("t5_rst_rsp", {30'd0, rsp_valid}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK); #1;
    chk("t5_no_rsp", {30'd0, rsp_valid}, 0);
    req_write = 2'b00;
    req_addr  = {4'hC, 4'h0};
    req_valid = 2'b11;
    #1;
    grant_wait(2'b01, "t5_g0");
    rsp_wait(2'b01, 1, 2'b00, "t5_r0");
    grant_wait(2'b10, "t5_g1");
    rsp_wait(2'b10, 4, 2'b00, "t5_r1");
    txn(1, 1'b0, 4'h8, 0, 32'h55, 2'b00, "t5_r1b");

    // 6: error responses pass through; address aligned.
    bresp_val = RESP_SLVERR;
    txn(0, 1'b1, 4'h6, 32'h66, 0, RESP_SLVERR, "t6_w");
    chk("t6_awaddr", {28'd0, last_awaddr}, 4'h4);
    bresp_val = RESP_OKAY;
    rresp_val = RESP_DECERR;
    txn(1, 1'b0, 4'h4, 0, 32'h66, RESP_DECERR, "t6_r");
    rresp_val = RESP_OKAY;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_reg_list_master_arb.md
Name: axi_reg_list_master_arb

Overview:
- Shares one AXI4-Lite master port, driving the register-list slave (S00_AXI, 4 x 32-bit registers), between two local requesters.
- Each requester presents a simple command (write/read, address, data). The block arbitrates round-robin and runs exactly one AXI4-Lite transaction at a time.
- Returns the read data and response to the owning requester.
- Sits between fabric control logic (sequencers, CPU-less config engines) and the register-list slave.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI byte-address width; 4 registers x 4 bytes.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_NUM_REQ, 2, number of requesters; fixed at 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
- req_valid  in  2  per-requester command valid; must be held until req_ready.
- req_ready  out  2  one-cycle grant/accept pulse, one-hot.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*AW  packed byte addresses; requester i at [i*AW +: AW].
- req_wdata  in  64  packed write data.
- rsp_valid  out  2  one-cycle completion pulse, one-hot; no backpressure.
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  AXI4-Lite write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  AXI4-Lite write data channel.
- M_AXI_BRESP/BVALID/BREADY  AXI4-Lite write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  AXI4-Lite read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY  AXI4-Lite read data channel.
- Clock/reset: one clock ACLK; ARESETN is synchronous, active-low.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie.

FSM states and transitions:
- IDLE: if any req_valid, grant one requester.
  - Grant rule: if only one is valid, grant it; if both are valid, grant the one != last_grant.
  - On grant: req_ready[g] = 1 for that cycle; latch write, addr, wdata and owner; update last_grant.
  - Next state is WR_REQ if write, else RD_REQ.
- WR_REQ: AWVALID and WVALID rise together in the cycle after the grant.
  - Each channel drops independently on its own handshake, tracked by aw_done/w_done flags.
  - Go to WR_RESP when both channels are done; this includes both handshakes in the same cycle.
- WR_RESP: BREADY = 1. On BVALID&BREADY, latch BRESP and go to DONE.
- RD_REQ: ARVALID = 1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY = 1. On RVALID&RREADY, latch RDATA/RRESP and go to DONE.
- DONE: rsp_valid[owner] = 1 for one cycle with rdata/resp, then IDLE.
  - A new grant is possible at the earliest in the following IDLE cycle.

AXI signal rules:
- AWADDR/ARADDR = latched addr with bits [1:0] forced to 0.
- WSTRB = 4'hF; AWPROT = ARPROT = 3'b000.
- AXI VALID signals are registered and never deasserted before their handshake.
- Addresses, data and VALIDs are stable while VALID is high.

Latency, zero-wait slave:
- Write: grant at N, AW/W at N+1, BVALID at N+2, rsp_valid at N+3.
- Read: grant at N, AR at N+1, RVALID at N+2, rsp_valid at N+3.

Boundary conditions:
- Only one outstanding transaction.
- req_valid arriving while busy waits; it is not dropped.
- A requester may drop req_valid before grant; nothing is issued for it.
- Error responses (SLVERR 2'b10, DECERR 2'b11) pass through unchanged.
- Mid-transaction ARESETN low: next edge returns to IDLE, all VALID/READY low, no rsp_valid, last_grant = 1.

Decomposition:
- Package axi_reg_arb_pkg holds:
  - state enum {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE};
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - C_ADDR_LSB = 2.
- Sub-module rr_arbiter_2: combinational grant from req_valid and last_grant, plus a registered last_grant update on accept. Everything else lives in the top FSM.

Test Plan:
1. req0 write addr 0x4 data 0xA5A50001, slave zero-wait -> AWADDR=0x4, WDATA=0xA5A50001, WSTRB=0xF; rsp_valid=2'b01 3 cycles after grant, rsp_resp=00. Then req0 read 0x4 -> rsp_rdata=0xA5A50001.
2. Both requesters valid in the same cycle after reset (req0 write 0x0=1, req1 write 0x8=3) -> req_ready=01 first, then 10. A second simultaneous pair -> req0 granted first again (last_grant=1).
3. Slave holds AWREADY low 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, BREADY only after both handshakes, single rsp_valid.
4. Writes 1,2,3,4 to 0x0..0xC via alternating requesters, then reads of all four -> rdata 1,2,3,4, each returned to the issuing requester.
5. ARESETN low for 1 cycle during WR_RESP -> all M_AXI VALID/READY and rsp_valid 0. After release, a req1 read issues normally and wins over req0 only if req0 is idle.
6. Slave answers BRESP=2'b10 on a write, then RRESP=2'b11 on a read -> rsp_resp 2'b10 then 2'b11; rsp_rdata=0 for the write.
